// File: rtl/mx_fp_pkg.sv
// Shared definitions for the MX minifloat datapath: derived widths and the
// operand classification produced by the field decoder.
package mx_fp_pkg;

    // Operand class from the exponent/mantissa fields. There are no inf/NaN
    // codes, so every non-zero encoding is either subnormal or normal.
    typedef enum logic [1:0] {
        ClsZero = 2'd0,
        ClsSub  = 2'd1,
        ClsNorm = 2'd2
    } fp_class_e;

    // Operand width: {sign, exp[E-1:0], man[M-1:0]}.
    function automatic int unsigned bit_width(input int unsigned e, input int unsigned m);
        return 1 + e + m;
    endfunction

    // Product width. The largest magnitude is (2^(M+1)-1)^2 << (2^(E+1)-4),
    // which needs 2^(E+1)+2M-2 bits; one more for the sign, plus one spare.
    function automatic int unsigned prd_width(input int unsigned e, input int unsigned m);
        return 2 * ((1 << e) + m);
    endfunction

    // Significand width including the implicit leading bit.
    function automatic int unsigned sig_width(input int unsigned m);
        return m + 1;
    endfunction

    // Width of the summed scale: each scale is at most 2^E-2, so the sum is
    // at most 2^(E+1)-4 and fits in E+1 bits.
    function automatic int unsigned shift_width(input int unsigned e);
        return e + 1;
    endfunction

endpackage

// File: rtl/mul_fp6_core_if.sv
// Operand/product bundle for mul_fp6_core. The master drives operands and
// consumes the product; the multiplier is the slave.
interface mul_fp6_core_if
    import mx_fp_pkg::*;
#(
    parameter int unsigned exp_width = 3,
    parameter int unsigned man_width = 2
);

    localparam int unsigned BitWidth = bit_width(exp_width, man_width);
    localparam int unsigned PrdWidth = prd_width(exp_width, man_width);

    logic                i_valid;
    logic [BitWidth-1:0] i_op0;
    logic [BitWidth-1:0] i_op1;
    logic                o_valid;
    logic [PrdWidth-1:0] o_prd;

    modport master (
        output i_valid,
        output i_op0,
        output i_op1,
        input  o_valid,
        input  o_prd
    );

    modport slave (
        input  i_valid,
        input  i_op0,
        input  i_op1,
        output o_valid,
        output o_prd
    );

endinterface

// File: rtl/fp_decode.sv
// Minifloat field decoder: splits {sign, exp, man}, restores the implicit
// leading bit for normals and produces the power-of-two scale and class.
// Purely combinational.
module fp_decode
    import mx_fp_pkg::*;
#(
    parameter int unsigned exp_width = 3,
    parameter int unsigned man_width = 2
) (
    input  logic [exp_width+man_width:0] op_i,
    output logic                         sign_o,
    output logic [man_width:0]           sig_o,
    output logic [exp_width-1:0]         scale_o,
    output fp_class_e                    cls_o
);

    logic [exp_width-1:0] exp_f;
    logic [man_width-1:0] man_f;

    assign sign_o = op_i[exp_width+man_width];
    assign exp_f  = op_i[man_width +: exp_width];
    assign man_f  = op_i[man_width-1:0];

    // Subnormals (exp==0) share scale 0 with exp==1; normals gain the hidden one.
    always_comb begin
        sig_o   = {1'b0, man_f};
        scale_o = '0;
        cls_o   = ClsZero;
        if (exp_f == '0) begin
            if (man_f != '0) begin
                cls_o = ClsSub;
            end
        end else begin
            sig_o   = {1'b1, man_f};
            scale_o = exp_f - exp_width'(1);
            cls_o   = ClsNorm;
        end
    end

endmodule

// File: rtl/mul_fp6_core.sv
// Exact minifloat multiplier. Two decoded operands are multiplied as
// integers, shifted by the summed scale and negated when the signs differ.
// The result is a two's-complement fixed-point value scaled so that the
// smallest subnormal squared is 1. One register stage at the output.
module mul_fp6_core
    import mx_fp_pkg::*;
#(
    parameter int unsigned exp_width = 3,
    parameter int unsigned man_width = 2
) (
    input logic           clk,
    input logic           rst,
    mul_fp6_core_if.slave bus
);

    localparam int unsigned BitWidth    = bit_width(exp_width, man_width);
    localparam int unsigned PrdWidth    = prd_width(exp_width, man_width);
    localparam int unsigned SigWidth    = sig_width(man_width);
    localparam int unsigned SigPrdWidth = 2 * SigWidth;
    localparam int unsigned ShWidth     = shift_width(exp_width);

    logic                   sign0, sign1;
    logic [SigWidth-1:0]    sig0, sig1;
    logic [exp_width-1:0]   scale0, scale1;
    fp_class_e              cls0, cls1;

    logic [SigPrdWidth-1:0] sig_prd;
    logic [ShWidth-1:0]     shamt;
    logic [PrdWidth-1:0]    mag;
    logic                   neg;

    logic [PrdWidth-1:0]    prd_d, prd_q;
    logic                   valid_d, valid_q;

    logic [BitWidth-1:0]    op0, op1;

    assign op0 = bus.i_op0;
    assign op1 = bus.i_op1;

    fp_decode #(
        .exp_width (exp_width),
        .man_width (man_width)
    ) u_dec0 (
        .op_i    (op0),
        .sign_o  (sign0),
        .sig_o   (sig0),
        .scale_o (scale0),
        .cls_o   (cls0)
    );

    fp_decode #(
        .exp_width (exp_width),
        .man_width (man_width)
    ) u_dec1 (
        .op_i    (op1),
        .sign_o  (sign1),
        .sig_o   (sig1),
        .scale_o (scale1),
        .cls_o   (cls1)
    );

    // Magnitude multiply, barrel shift and conditional negate.
    always_comb begin
        sig_prd = SigPrdWidth'(sig0) * SigPrdWidth'(sig1);
        shamt   = ShWidth'(scale0) + ShWidth'(scale1);
        mag     = PrdWidth'(sig_prd) << shamt;
        // A zero operand never negates, so sign-bit-set zeros give +0.
        neg     = (sign0 ^ sign1) && (cls0 != ClsZero) && (cls1 != ClsZero);
        prd_d   = neg ? (~mag + PrdWidth'(1)) : mag;
        valid_d = bus.i_valid;
    end

    // Output register; loads every cycle, valid tracks the operand valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            prd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            prd_q   <= prd_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_prd   = prd_q;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_mul_fp6_core.sv
// Bench for mul_fp6_core at E=5, M=2 (8-bit operands, 68-bit product).
module tb_mul_fp6_core;

    localparam int unsigned E  = 5;
    localparam int unsigned M  = 2;
    localparam int unsigned BW = 1 + E + M;
    localparam int unsigned PW = 2 * ((1 << E) + M);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_fp6_core_if #(.exp_width(E), .man_width(M)) bus ();

    mul_fp6_core #(
        .exp_width (E),
        .man_width (M)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // val(x) = (-1)^s * sig * 2^max(e,1) * 2^-M; result = val(a)*val(b)/val(1)^2.
    // With val(1) = 2^(1-M) this reduces to sig_a*sig_b*2^(max(ea,1)+max(eb,1)-2).
    function automatic logic [PW-1:0] ref_prd(input int unsigned a, input int unsigned b);
        int unsigned ea, eb, ma, mb, sa, sb, ga, gb, xa, xb;
        logic signed [127:0] v;
        ea = (a >> M) % (1 << E);
        eb = (b >> M) % (1 << E);
        ma = a % (1 << M);
        mb = b % (1 << M);
        sa = (a >> (E + M)) % 2;
        sb = (b >> (E + M)) % 2;
        ga = (ea == 0) ? ma : (1 << M) + ma;
        gb = (eb == 0) ? mb : (1 << M) + mb;
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        v = 128'(ga * gb);
        v = v << (xa + xb - 2);
        if (sa != sb) v = -v;
        return v[PW-1:0];
    endfunction

    task automatic drive(input logic v, input int unsigned a, input int unsigned b);
        bus.i_valid = v;
        bus.i_op0   = BW'(a);
        bus.i_op1   = BW'(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom_range(255), $urandom_range(255));
            tick();
            checks++;
            if (bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid edge %0d got %b exp 0", i, bus.o_valid);
            end
            checks++;
            if (bus.o_prd !== '0) begin
                errors++;
                $display("FAIL reset_prd edge %0d got %0h exp 0", i, bus.o_prd);
            end
        end
        rst = 1'b0;
        drive(1'b1, 'h3C, 'h7F);
        tick();
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_valid got %b exp 1", bus.o_valid);
        end
        checks++;
        if (bus.o_prd !== ref_prd('h3C, 'h7F)) begin
            errors++;
            $display("FAIL release_prd got %0h exp %0h", bus.o_prd, ref_prd('h3C, 'h7F));
        end
    endtask

    task automatic test_directed();
        int unsigned   a_tab [7];
        int unsigned   b_tab [7];
        logic [PW-1:0] e_tab [7];
        logic [PW-1:0] one;
        one = PW'(1);
        a_tab = '{'h01, 'h81, 'h04, 'h3C, 'h7F, 'h80, 'hFF};
        b_tab = '{'h01, 'h01, 'h01, 'h01, 'h7F, 'h7F, 'h80};
        e_tab[0] = one;
        e_tab[1] = '1;
        e_tab[2] = PW'(4);
        e_tab[3] = PW'(65536);
        e_tab[4] = PW'(49) << 60;
        e_tab[5] = '0;
        e_tab[6] = '0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, a_tab[i], b_tab[i]);
            tick();
            checks++;
            if (bus.o_prd !== e_tab[i]) begin
                errors++;
                $display("FAIL directed %02h*%02h got %0h exp %0h",
                         a_tab[i], b_tab[i], bus.o_prd, e_tab[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [PW-1:0] e;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(1'b1, a, b);
                tick();
                e = ref_prd(a, b);
                checks++;
                if (bus.o_prd !== e || bus.o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep %02h*%02h got %0h/v%b exp %0h/v1",
                             a, b, bus.o_prd, bus.o_valid, e);
                end
            end
        end
    endtask

    // Random operands with i_valid toggling and one mid-stream reset pulse.
    task automatic test_back_to_back();
        int unsigned   a, b;
        logic          v, r;
        logic [PW-1:0] e;
        for (int i = 0; i < 300; i++) begin
            a = $urandom_range(255);
            b = $urandom_range(255);
            v = 1'($urandom_range(1));
            r = (i == 150);
            rst = r;
            drive(v, a, b);
            tick();
            e = r ? '0 : ref_prd(a, b);
            checks++;
            if (bus.o_valid !== (v & ~r)) begin
                errors++;
                $display("FAIL b2b_valid cyc %0d got %b exp %b", i, bus.o_valid, v & ~r);
            end
            checks++;
            if (bus.o_prd !== e) begin
                errors++;
                $display("FAIL b2b_prd cyc %0d %02h*%02h got %0h exp %0h",
                         i, a, b, bus.o_prd, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 0, 0);
        test_reset();
        test_directed();
        test_exhaustive();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
